// File: rtl/pc_unit_ras_pkg.sv
// Shared types and constants for the IF-stage PC unit and its return-address stack.
// Optional exception vectoring is enabled by defining PC_UNIT_EXC_VECTOR_EN.
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ,
        PC_REDIR,
        PC_CALL,
        PC_RET,
        PC_EXC
    } pc_act_e;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h8000_0180;

    function automatic int ras_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/pc_ras_stack.sv
// Circular LIFO of return addresses; when full, a push overwrites the oldest entry.
// Sticky overflow/underflow flags survive a flush and clear only on reset.
module pc_ras_stack
    import pc_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int PW   = ras_ptr_w(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  top,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          unf
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] top_idx;
    logic          empty;
    logic          full;

    assign top_idx = ptr - PW'(1);
    assign empty   = (count == '0);
    assign full    = (count == FULL);
    assign top     = empty ? '0 : mem[top_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            mem[ptr] <= push_data;
            ptr      <= ptr + PW'(1);
            if (full) begin
                ovf <= 1'b1;
            end else begin
                count <= count + CW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                ptr   <= top_idx;
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch PC register with stall, redirect and an internal return-address stack.
// Define PC_UNIT_EXC_VECTOR_EN to add the exc input and EXC_VECTOR parameter.
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
    parameter int                INC        = 4,
`ifdef PC_UNIT_EXC_VECTOR_EN
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR),
`endif
    parameter int                RAS_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pc_write,
    input  logic                         redirect,
    input  logic                         call,
    input  logic                         ret,
`ifdef PC_UNIT_EXC_VECTOR_EN
    input  logic                         exc,
`endif
    input  logic [ADDR_W-1:0]            redirect_pc,
    output logic [ADDR_W-1:0]            pc,
    output logic [ADDR_W-1:0]            ras_top,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    pc_act_e           act;
    logic              upd;
    logic              push;
    logic              pop;
    logic              flush;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_next;

    assign pc_inc = pc + ADDR_W'(INC);

`ifdef PC_UNIT_EXC_VECTOR_EN
    assign upd = pc_write | exc;
`else
    assign upd = pc_write;
`endif

    always_comb begin
        act = PC_SEQ;
        priority case (1'b1)
`ifdef PC_UNIT_EXC_VECTOR_EN
            exc:      act = PC_EXC;
`endif
            ret:      act = PC_RET;
            call:     act = PC_CALL;
            redirect: act = PC_REDIR;
            default:  act = PC_SEQ;
        endcase
    end

    always_comb begin
        pc_next = pc_inc;
        unique case (act)
            PC_REDIR: pc_next = redirect_pc;
            PC_CALL:  pc_next = redirect_pc;
            // Empty-stack return falls through; ID will correct it.
            PC_RET:   pc_next = (ras_count != '0) ? ras_top : pc_inc;
`ifdef PC_UNIT_EXC_VECTOR_EN
            PC_EXC:   pc_next = EXC_VECTOR;
`endif
            default:  pc_next = pc_inc;
        endcase
    end

    assign push  = upd && (act == PC_CALL);
    assign pop   = upd && (act == PC_RET);
    assign flush = upd && (act == PC_EXC);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (upd) begin
            pc <= pc_next;
        end
    end

    pc_ras_stack #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_count),
        .ovf       (ras_ovf),
        .unf       (ras_unf)
    );

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised program-counter unit for the pipelined MIPS core. Successor to the fetch-stage PC register.
- Holds the fetch PC and supports stall, sequential increment and branch/jump redirect.
- Adds an internal return-address stack (RAS): a call pushes the link address, and a return pops its target without an ID-stage compare.
- Sits in IF; its control comes from ID and hazard logic.

Parameters:
- ADDR_W, 32, width of the PC and of all addresses.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of RAS entries. Must be a power of two and at least 2.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset.
- pc_write, input, 1, update enable; 0 = stall (PC and RAS hold).
- redirect, input, 1, plain branch/jump taken; next PC = redirect_pc.
- call, input, 1, jal/jalr; next PC = redirect_pc and push pc+INC.
- ret, input, 1, jr $ra; next PC = RAS top, then pop.
- redirect_pc, input, ADDR_W, branch/jump/call target.
- pc, output, ADDR_W, current fetch PC.
- ras_top, output, ADDR_W, current top-of-stack entry (0 when empty).
- ras_count, output, $clog2(RAS_DEPTH)+1, number of valid entries.
- ras_ovf, output, 1, sticky flag: a push happened while full.
- ras_unf, output, 1, sticky flag: a ret happened while empty.

Behaviour:
- Reset: rst low asynchronously forces pc=RESET_PC, ras_count=0, stack pointer=0, ras_ovf=0, ras_unf=0 and all entries=0. Release is synchronous to the next clk.
- All updates occur on the rising clk edge only when pc_write=1. With pc_write=0, every register holds and call/ret/redirect are ignored, with no RAS side effects.
- Single-winner priority when pc_write=1: ret > call > redirect > sequential. Only the winner's PC and RAS effect apply.
- ret, count>0: pc <= ras_top; count decrements; pointer moves down.
- ret, count=0: pc <= pc+INC (fall-through); ras_unf <= 1; RAS unchanged.
- call, count<DEPTH: pc <= redirect_pc; push pc+INC; count increments.
- call, count=DEPTH: pc <= redirect_pc; the push overwrites the oldest entry (circular); count stays DEPTH; ras_ovf <= 1.
- redirect: pc <= redirect_pc; RAS unchanged.
- Sequential: pc <= pc+INC.
- Arithmetic: pc+INC wraps modulo 2^ADDR_W, so 32'hFFFF_FFFC+4 gives 0. No alignment check is made on redirect_pc.
- Latency: one cycle from control inputs to pc. ras_top and ras_count reflect the registered state and update in the same edge as pc.
- A deep-call sequence past DEPTH returns correctly for the newest DEPTH levels only; older returns mispredict. That is acceptable, because ID-stage redirect corrects them.

Optional Feature:
- Macro: PC_UNIT_EXC_VECTOR_EN.
- Defined: adds input exc (1 bit) and parameter EXC_VECTOR (default 32'h8000_0180).
  - exc has top priority over ret/call/redirect and acts even when pc_write=0.
  - pc <= EXC_VECTOR; RAS is flushed (count=0, pointer=0); sticky flags are kept.
- Undefined: no exc port and no EXC_VECTOR parameter; behaviour exactly as above.

Decomposition:
- Shared package pc_pkg:
  - action encoding typedef (PC_SEQ, PC_REDIR, PC_CALL, PC_RET, PC_EXC).
  - RAS pointer-width constant function.
  - default RESET_PC and EXC_VECTOR constants.
- Sub-module pc_ras_stack: circular LIFO with push, pop, flush, top, count, ovf and unf.
- Top level: priority decode plus the PC register.

Test Plan:
- Reset then 3 idle cycles with pc_write=1 -> pc = 0, 4, 8, 12; ras_count=0; flags 0.
- pc=0x10, call with redirect_pc=0x100 -> pc=0x100, ras_top=0x14, count=1. Then ret -> pc=0x14, count=0.
- pc_write=0 for 3 cycles with call=1 and ret=1 asserted -> pc, ras_top and ras_count unchanged.
- 5 calls with DEPTH=4 (links 0x4, 0x104, 0x204, 0x304, 0x404) -> count=4, ras_ovf=1. Then 4 rets yield 0x404, 0x304, 0x204, 0x104. A 5th ret at count=0 -> pc=prev+4 and ras_unf=1.
- Simultaneous ret+call+redirect at count=1 (top=0x40) -> pc=0x40, count=0, no push. Also: pc=0xFFFF_FFFC sequential -> pc=0.
- rst pulsed low mid-cycle during a call burst -> pc=RESET_PC and count=0 immediately, without waiting for clk. With PC_UNIT_EXC_VECTOR_EN defined: exc with pc_write=0 -> pc=0x8000_0180 and count=0.
